// File: rtl/qam16_pkg.sv
// Shared types and constants for the 16-QAM transmit frame controller.
package qam16_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRE   = 2'd1,
      ST_PAY   = 2'd2,
      ST_GUARD = 2'd3
   } frame_state_t;

   localparam int SYMW = 4;

   localparam logic [SYMW-1:0] DEF_PRE_SYM_A = 4'h0;
   localparam logic [SYMW-1:0] DEF_PRE_SYM_B = 4'hF;
   localparam logic [SYMW-1:0] DEF_FILL_SYM  = 4'h0;

endpackage

// File: rtl/qam16_sym_tick.sv
// Symbol-slot divider: counts 0..SYM_DIV-1 while enabled and flags the first and last clock of each slot.
module qam16_sym_tick #(
   parameter int SYM_DIV = 16,
   parameter int DIV_W   = $clog2(SYM_DIV)
) (
   input  logic             CLK,
   input  logic             Rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [DIV_W-1:0] div_cnt,
   output logic             slot_start,
   output logic             slot_end
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SYM_DIV - 1);

   always_ff @(posedge CLK or negedge Rst_n) begin
      if (!Rst_n) begin
         div_cnt <= '0;
      end else if (clr) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      end
   end

   assign slot_start = (div_cnt == '0);
   assign slot_end   = (div_cnt == DIV_LAST);

endmodule

// File: rtl/qam16_tx_frame_ctrl.sv
// Burst sequencer for the 16-QAM modulator: preamble, payload pulled from a valid/ready source, silent guard.
module qam16_tx_frame_ctrl
   import qam16_pkg::*;
#(
   parameter int              SYM_DIV   = 16,
   parameter int              PRE_LEN   = 16,
   parameter int              PAY_LEN   = 64,
   parameter int              GUARD_LEN = 8,
   parameter logic [SYMW-1:0] PRE_SYM_A = DEF_PRE_SYM_A,
   parameter logic [SYMW-1:0] PRE_SYM_B = DEF_PRE_SYM_B,
   parameter logic [SYMW-1:0] FILL_SYM  = DEF_FILL_SYM
) (
   input  logic            CLK,
   input  logic            Rst_n,
   input  logic            start,
   input  logic [SYMW-1:0] din,
   input  logic            din_valid,
   output logic            din_ready,
   output logic [SYMW-1:0] sym_out,
   output logic            sym_stb,
   output logic            mod_en,
   output logic            nco_rst,
   output logic            busy,
   output logic            frame_done,
   output logic            underrun
);

   localparam int DIV_W   = $clog2(SYM_DIV);
   localparam int MAX_LEN = (PRE_LEN > PAY_LEN)
                            ? ((PRE_LEN > GUARD_LEN) ? PRE_LEN : GUARD_LEN)
                            : ((PAY_LEN > GUARD_LEN) ? PAY_LEN : GUARD_LEN);
   localparam int CNT_W   = $clog2(MAX_LEN + 1);

   localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_LEN - 1);
   localparam logic [CNT_W-1:0] PAY_LAST   = CNT_W'(PAY_LEN - 1);
   localparam logic [CNT_W-1:0] GUARD_DONE = CNT_W'(GUARD_LEN);

   frame_state_t     state, state_nxt;
   logic [CNT_W-1:0] slot_cnt, slot_cnt_nxt;
   logic [SYMW-1:0]  sym_out_nxt;
   logic             sym_stb_nxt, mod_en_nxt, nco_rst_nxt;
   logic             busy_nxt, frame_done_nxt, underrun_nxt;

   logic [DIV_W-1:0] div_cnt;
   logic             slot_start, slot_end;
   logic             tick_en, tick_clr;

   assign tick_en  = (state != ST_IDLE);
   assign tick_clr = (state_nxt == ST_IDLE);

   qam16_sym_tick #(
      .SYM_DIV (SYM_DIV),
      .DIV_W   (DIV_W)
   ) u_sym_tick (
      .CLK        (CLK),
      .Rst_n      (Rst_n),
      .en         (tick_en),
      .clr        (tick_clr),
      .div_cnt    (div_cnt),
      .slot_start (slot_start),
      .slot_end   (slot_end)
   );

   assign din_ready = (state == ST_PAY) && slot_start;

   always_ff @(posedge CLK or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= ST_IDLE;
         slot_cnt   <= '0;
         sym_out    <= '0;
         sym_stb    <= 1'b0;
         mod_en     <= 1'b0;
         nco_rst    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state      <= state_nxt;
         slot_cnt   <= slot_cnt_nxt;
         sym_out    <= sym_out_nxt;
         sym_stb    <= sym_stb_nxt;
         mod_en     <= mod_en_nxt;
         nco_rst    <= nco_rst_nxt;
         busy       <= busy_nxt;
         frame_done <= frame_done_nxt;
         underrun   <= underrun_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      slot_cnt_nxt   = slot_cnt;
      sym_out_nxt    = sym_out;
      sym_stb_nxt    = 1'b0;
      mod_en_nxt     = mod_en;
      nco_rst_nxt    = 1'b0;
      busy_nxt       = busy;
      frame_done_nxt = 1'b0;
      underrun_nxt   = underrun;

      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt    = ST_PRE;
               slot_cnt_nxt = '0;
               busy_nxt     = 1'b1;
               nco_rst_nxt  = 1'b1;
               mod_en_nxt   = 1'b1;
               underrun_nxt = 1'b0;
            end
         end

         ST_PRE: begin
            if (slot_start) begin
               sym_out_nxt = slot_cnt[0] ? PRE_SYM_B : PRE_SYM_A;
               sym_stb_nxt = 1'b1;
            end
            if (slot_end) begin
               if (slot_cnt == PRE_LAST) begin
                  state_nxt    = ST_PAY;
                  slot_cnt_nxt = '0;
               end else begin
                  slot_cnt_nxt = slot_cnt + 1'b1;
               end
            end
         end

         ST_PAY: begin
            // An empty source still consumes the slot so burst length never changes.
            if (slot_start) begin
               sym_stb_nxt = 1'b1;
               if (din_valid) begin
                  sym_out_nxt = din;
               end else begin
                  sym_out_nxt  = FILL_SYM;
                  underrun_nxt = 1'b1;
               end
            end
            if (slot_end) begin
               if (slot_cnt == PAY_LAST) begin
                  state_nxt    = ST_GUARD;
                  slot_cnt_nxt = '0;
                  mod_en_nxt   = 1'b0;
               end else begin
                  slot_cnt_nxt = slot_cnt + 1'b1;
               end
            end
         end

         ST_GUARD: begin
            // Close on the slot boundary after the last guard slot, aligned with the strobe grid.
            if (slot_start && (slot_cnt == GUARD_DONE)) begin
               state_nxt      = ST_IDLE;
               slot_cnt_nxt   = '0;
               busy_nxt       = 1'b0;
               frame_done_nxt = 1'b1;
            end else if (slot_end) begin
               slot_cnt_nxt = slot_cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_qam16_tx_frame_ctrl.sv
// Scoreboard bench for qam16_tx_frame_ctrl with SYM_DIV=4, PRE_LEN=2, PAY_LEN=4, GUARD_LEN=1.
module tb_qam16_tx_frame_ctrl;

   localparam int SD   = 4;
   localparam int FLEN = (2 + 4 + 1) * SD + 1;

   logic       CLK = 1'b0;
   logic       Rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] din = 4'h0;
   logic       din_valid = 1'b0;
   logic       din_ready;
   logic [3:0] sym_out;
   logic       sym_stb, mod_en, nco_rst, busy, frame_done, underrun;

   qam16_tx_frame_ctrl #(
      .SYM_DIV   (4),
      .PRE_LEN   (2),
      .PAY_LEN   (4),
      .GUARD_LEN (1),
      .PRE_SYM_A (4'h0),
      .PRE_SYM_B (4'hF),
      .FILL_SYM  (4'h0)
   ) dut (
      .CLK        (CLK),
      .Rst_n      (Rst_n),
      .start      (start),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .sym_out    (sym_out),
      .sym_stb    (sym_stb),
      .mod_en     (mod_en),
      .nco_rst    (nco_rst),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] sym;
      int         cyc;
   } exp_t;

   exp_t       sym_q[$];
   int         done_q[$];
   logic [4:0] feed_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int nco_cnt = 0, nco_cyc = -1, hs_cnt = 0, rdy_cnt = 0, stb_cnt = 0;
   int done_cnt = 0, fall_cyc = -1;
   logic mod_en_q = 1'b0;
   exp_t mon_e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // Payload source: offers the next queued nibble whenever the slot window opens.
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (din_ready) begin
            if (feed_q.size() > 0) begin
               {din_valid, din} = feed_q.pop_front();
            end else begin
               din_valid = 1'b0;
               din       = 4'h0;
            end
         end else begin
            din_valid = 1'b1;
            din       = 4'hA;
         end
      end
   end

   // Monitor: compares every strobe and frame_done against the scoreboard.
   always @(negedge CLK) begin
      if (sym_stb) begin
         stb_cnt++;
         if (sym_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stb_unexpected sym_out=%h at cyc %0d, required no strobe", sym_out, cyc);
         end else begin
            mon_e = sym_q.pop_front();
            chk("stb_sym", {28'd0, sym_out}, {28'd0, mon_e.sym});
            chk("stb_cyc", cyc, mon_e.cyc);
         end
      end
      if (frame_done) begin
         done_cnt++;
         if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected frame_done at cyc %0d, required none", cyc);
         end else begin
            chk("done_cyc", cyc, done_q.pop_front());
         end
      end
      if (nco_rst) begin
         nco_cnt++;
         nco_cyc = cyc;
      end
      if (mod_en_q && !mod_en) fall_cyc = cyc;
      mod_en_q = mod_en;
      if (din_ready) rdy_cnt++;
      if (din_ready && din_valid) hs_cnt++;
   end

   function automatic logic [9:0] outs();
      return {sym_out, sym_stb, mod_en, nco_rst, busy, frame_done, underrun};
   endfunction

   task automatic do_frame(input logic [15:0] pay, input logic [3:0] vmask,
                           input logic [23:0] exp_syms, input int exp_hs,
                           input logic exp_und, input bit poke);
      int a, nco0, hs0, rdy0, done0, n;
      @(negedge CLK);
      nco0  = nco_cnt;
      hs0   = hs_cnt;
      rdy0  = rdy_cnt;
      done0 = done_cnt;
      for (int k = 0; k < 4; k++) feed_q.push_back({vmask[3-k], pay[15-4*k -: 4]});
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      a = cyc;
      for (int k = 0; k < 6; k++) sym_q.push_back('{sym: exp_syms[23-4*k -: 4], cyc: a + 1 + 4*k});
      done_q.push_back(a + FLEN);
      chk("accept_ctrl", {28'd0, nco_rst, busy, mod_en, underrun}, 32'h0000_000E);
      if (poke) begin
         while (cyc < a + 12) @(negedge CLK);
         start = 1'b1;
         @(negedge CLK);
         start = 1'b0;
         while (cyc < a + FLEN - 1) @(negedge CLK);
         start = 1'b1;
         @(negedge CLK);
         start = 1'b0;
      end
      n = 0;
      while (done_cnt == done0 && n < 80) begin
         @(negedge CLK);
         n++;
      end
      if (done_cnt == done0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout frame_done count %0d, required %0d", done_cnt, done0 + 1);
      end
      chk("nco_pulses", nco_cnt - nco0, 1);
      chk("nco_cyc", nco_cyc, a);
      chk("handshakes", hs_cnt - hs0, exp_hs);
      chk("ready_cycles", rdy_cnt - rdy0, 4);
      chk("mod_en_fall", fall_cyc, a + 24);
      chk("end_ctrl", {29'd0, busy, mod_en, underrun}, {31'd0, exp_und});
      if (poke) begin
         repeat (8) @(negedge CLK);
         chk("no_restart_busy", {31'd0, busy}, 0);
         chk("no_restart_nco", nco_cnt - nco0, 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout cyc=%0d required finish", cyc);
      $fatal(1);
   end

   initial begin
      Rst_n = 1'b0;
      repeat (3) @(negedge CLK);
      chk("reset_outs", {22'd0, outs()}, 0);
      Rst_n = 1'b1;
      repeat (20) @(negedge CLK);
      chk("idle_outs", {22'd0, outs()}, 0);
      chk("idle_no_stb", stb_cnt, 0);
      chk("idle_no_ready", rdy_cnt, 0);

      // Nominal burst: 0,F preamble then 3,7,B,C.
      do_frame(16'h37BC, 4'b1111, 24'h0F37BC, 4, 1'b0, 1'b0);

      // Slot 2 of the payload starves: fill symbol, sticky underrun.
      do_frame(16'h1204, 4'b1101, 24'h0F1204, 3, 1'b1, 1'b0);
      repeat (5) @(negedge CLK);
      chk("underrun_sticky", {31'd0, underrun}, 1);

      // start pulses mid-payload and on the return-to-idle edge are ignored.
      do_frame(16'hE5D2, 4'b1111, 24'h0FE5D2, 4, 1'b0, 1'b1);

      // Asynchronous abort in the middle of the payload.
      begin
         int a;
         @(negedge CLK);
         for (int k = 0; k < 4; k++) feed_q.push_back(5'h19);
         start = 1'b1;
         @(negedge CLK);
         start = 1'b0;
         a = cyc;
         sym_q.push_back('{sym: 4'h0, cyc: a + 1});
         sym_q.push_back('{sym: 4'hF, cyc: a + 5});
         sym_q.push_back('{sym: 4'h9, cyc: a + 9});
         while (cyc < a + 12) @(negedge CLK);
         chk("pre_abort", {22'd0, outs()}, {22'd0, 4'h9, 6'b010100});
         #2;
         Rst_n = 1'b0;
         #1;
         chk("abort_outs", {21'd0, outs(), din_ready}, 0);
         chk("abort_sym_q", sym_q.size(), 0);
         feed_q.delete();
         repeat (2) @(negedge CLK);
         Rst_n = 1'b1;
         repeat (3) @(negedge CLK);
         chk("post_abort_idle", {22'd0, outs()}, 0);
      end

      do_frame(16'h5A69, 4'b1111, 24'h0F5A69, 4, 1'b0, 1'b0);

      repeat (4) @(negedge CLK);
      chk("sym_q_drained", sym_q.size(), 0);
      chk("done_q_drained", done_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/qam16_tx_frame_ctrl.md
Name: qam16_tx_frame_ctrl

Overview:
Frame sequencer in front of the 16-QAM transmit modulator (mapper, mixer and output sum). Builds each burst as preamble symbols, then payload nibbles pulled from an upstream valid/ready source, then a silent guard interval. Issues one symbol strobe per SYM_DIV clocks and the modulator enable and NCO phase-reset controls.

Parameters:
SYM_DIV, 16, clocks per symbol slot (must be >= 2)
PRE_LEN, 16, preamble symbols per frame (>= 1)
PAY_LEN, 64, payload symbols per frame (>= 1)
GUARD_LEN, 8, guard slots after payload (>= 1)
PRE_SYM_A, 4'h0, preamble symbol in even slots
PRE_SYM_B, 4'hF, preamble symbol in odd slots
FILL_SYM, 4'h0, symbol inserted on payload underrun

Ports:
CLK  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
start  in  1  frame request, sampled only in IDLE
din  in  4  payload nibble (Gray-mapped by downstream mapper)
din_valid  in  1  din holds a nibble
din_ready  out  1  controller accepts din this cycle
sym_out  out  4  current symbol, registered, held between strobes
sym_stb  out  1  one-cycle pulse: new sym_out presented
mod_en  out  1  modulator output enable
nco_rst  out  1  one-cycle carrier phase reset
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at frame end
underrun  out  1  sticky: payload slot had no valid data

Behaviour:
- Reset (Rst_n low, asynchronous): all outputs 0, state IDLE, all counters 0. Reset asserted mid-frame aborts the frame immediately; there is no frame_done.
- States: IDLE, PRE, PAY, GUARD. Counters: div_cnt (0..SYM_DIV-1) and slot_cnt (per-state slot index).
- IDLE: if start=1 at an edge, the next state is PRE. At that same edge: busy<=1, nco_rst<=1 (one cycle), mod_en<=1, underrun<=0, div_cnt<=0, slot_cnt<=0.
- Slot timing: in PRE, PAY and GUARD, div_cnt increments every clock and wraps at SYM_DIV-1. A slot starts when div_cnt==0.
- PRE: at each slot start, sym_out<=PRE_SYM_A if slot_cnt is even, PRE_SYM_B if odd, and sym_stb<=1 for one cycle. After slot PRE_LEN-1 completes (div_cnt==SYM_DIV-1), go to PAY with slot_cnt<=0.
- PAY: din_ready = (state==PAY && div_cnt==0). This is combinational and lasts one cycle per slot.
  - At slot start with din_valid=1: sym_out<=din.
  - At slot start with din_valid=0: sym_out<=FILL_SYM and underrun<=1.
  - sym_stb<=1 in both cases.
  - The frame length is fixed: an underrun still consumes the slot.
  - After slot PAY_LEN-1 completes, go to GUARD.
- GUARD: mod_en<=0 on entry, no sym_stb, sym_out holds its last value. After GUARD_LEN full slots: frame_done<=1 (one cycle), busy<=0, state IDLE.
- Latency: the first sym_stb is registered at the first edge after the start-accept edge. Strobes are then exactly SYM_DIV cycles apart.
- Frame duration: start accept to frame_done = (PRE_LEN+PAY_LEN+GUARD_LEN)*SYM_DIV + 1 edges.
- start while busy=1 is ignored (no queueing). start=1 on the same edge that returns to IDLE is also ignored; it is seen from the next cycle.
- din_valid/din changes outside the ready window have no effect. No nibble is consumed outside PAY.
- Counter widths: $clog2 of the respective maximum. No wrap of slot_cnt beyond its state limit.

Decomposition:
- Package qam16_pkg:
  - frame state enum (IDLE/PRE/PAY/GUARD)
  - SYMW=4
  - default preamble and fill symbol constants
- Sub-module qam16_sym_tick: SYM_DIV divider with enable and synchronous clear.
  - Outputs slot_start (div_cnt==0) and slot_end (div_cnt==SYM_DIV-1).
  - Reuses the Rst_n async reset.

Test Plan:
Use SYM_DIV=4, PRE_LEN=2, PAY_LEN=4, GUARD_LEN=1 unless stated.
- Reset then idle: Rst_n low 3 cycles, then high with start=0 for 20 cycles -> all outputs 0, no sym_stb.
- Nominal frame: start pulse, din_valid held 1 with din=3,7,B,C -> sym_stb every 4 cycles carrying 0,F,3,7,B,C. nco_rst is a single pulse at accept. mod_en falls after C's slot. frame_done comes 29 edges after accept. underrun=0.
- Underrun: din_valid=0 during payload slot 2 -> sym_out=FILL_SYM(0) in that slot, underrun=1 sticky until the next start accept. 4 payload strobes still occur.
- Backpressure check: din_valid=1 continuously -> exactly 4 din_ready&din_valid handshakes per frame, each one cycle wide at div_cnt==0.
- start while busy: pulse start mid-payload -> no restart, no extra nco_rst, frame timing unchanged.
- Async reset mid-frame: drop Rst_n during PAY between edges -> outputs go to 0 immediately (without a clock edge). After release, start begins a fresh frame with preamble 0,F.
